// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - 4-digit multiplexed common-anode seven-segment driver
// Scans a once-per-frame snapshot of a packed BCD count with leading-zero blanking.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        grst,
  input  logic        enable,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done,
  output logic        digit_err
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    dp_shadow_q, dp_shadow_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;
  logic          digit_err_q, digit_err_d;

  logic          tick;
  logic          snap;
  logic          show;
  logic [15:0]   upper;
  logic [3:0]    nib;

  function automatic logic [6:0] seg_lut(input logic [3:0] n);
    case (n)
      4'd0:    seg_lut = 7'h40;
      4'd1:    seg_lut = 7'h79;
      4'd2:    seg_lut = 7'h24;
      4'd3:    seg_lut = 7'h30;
      4'd4:    seg_lut = 7'h19;
      4'd5:    seg_lut = 7'h12;
      4'd6:    seg_lut = 7'h02;
      4'd7:    seg_lut = 7'h78;
      4'd8:    seg_lut = 7'h00;
      4'd9:    seg_lut = 7'h10;
      default: seg_lut = 7'h3F;
    endcase
  endfunction

  function automatic logic any_bad(input logic [15:0] v);
    any_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  endfunction

  always_comb begin
    tick         = enable && (div_cnt_q == DIV_LAST);
    snap         = enable && (sel_q == 2'd0) && (div_cnt_q == '0);
    div_cnt_d    = div_cnt_q;
    if (enable) div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    sel_d        = tick ? sel_q + 2'd1 : sel_q;
    frame_done_d = tick && (sel_q == 2'd3);
    shadow_d     = snap ? bcd : shadow_q;
    dp_shadow_d  = snap ? dp_in : dp_shadow_q;
    digit_err_d  = snap ? any_bad(bcd) : digit_err_q;

    // Shifting the current nibble to the bottom leaves it plus all higher nibbles,
    // so a zero result means "this digit and everything left of it is zero".
    upper = shadow_q >> {sel_q, 2'b00};
    nib   = upper[3:0];
    show  = enable && !(BLANK_LZ && (sel_q != 2'd0) && (upper == 16'h0000));

    an_d  = show ? ~(4'b0001 << sel_q) : 4'b1111;
    seg_d = show ? seg_lut(nib) : 7'h7F;
    dp_d  = show ? ~dp_shadow_q[sel_q] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!grst) begin
      div_cnt_q    <= '0;
      sel_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      dp_shadow_q  <= 4'h0;
      an_q         <= 4'b1111;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
      digit_err_q  <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      sel_q        <= sel_d;
      shadow_q     <= shadow_d;
      dp_shadow_q  <= dp_shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
      digit_err_q  <= digit_err_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;
  assign digit_err  = digit_err_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - directed bench for seven_seg_scan_driver
// Frames are 16 cycles (REFRESH_DIV=4); outputs checked at the falling edge.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        grst;
  logic        enable;
  logic [15:0] bcd;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  logic        digit_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .grst(grst), .enable(enable), .bcd(bcd), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done), .digit_err(digit_err)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, 16'(an), 16'hF);
    chk({tag, "_seg"}, 16'(seg), 16'h7F);
    chk({tag, "_dp"}, 16'(dp), 16'h1);
    chk({tag, "_fd"}, 16'(frame_done), 16'h0);
    chk({tag, "_err"}, 16'(digit_err), 16'h0);
  endtask

  // One full frame starting at the snapshot edge; cycle 0 still shows the old snapshot.
  task automatic run_frame(input string tag, input logic [15:0] ean, input logic [27:0] eseg,
                           input logic [3:0] edp, input int chg_at, input logic [15:0] chg_bcd);
    int k;
    for (int f = 0; f < 16; f++) begin
      cyc();
      if (f == chg_at) bcd = chg_bcd;
      if (f != 0) begin
        k = f / 4;
        chk($sformatf("%s_an_f%0d", tag, f), 16'(an), 16'(ean[4*k +: 4]));
        chk($sformatf("%s_seg_f%0d", tag, f), 16'(seg), 16'(eseg[7*k +: 7]));
        chk($sformatf("%s_dp_f%0d", tag, f), 16'(dp), 16'(edp[k]));
      end
      chk($sformatf("%s_fd_f%0d", tag, f), 16'(frame_done), 16'(f == 15));
    end
  endtask

  localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  initial begin
    grst = 1'b0; enable = 1'b0; bcd = 16'h0000; dp_in = 4'h0;
    @(negedge clk);
    cyc(); cyc(); cyc();
    chk_reset("reset");

    grst = 1'b1; enable = 1'b1; bcd = 16'h1234;
    run_frame("f1234", AN_ALL, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, -1, 16'h0);
    chk("err_1234", 16'(digit_err), 16'h0);

    bcd = 16'h0007;
    run_frame("f0007", {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'hF, -1, 16'h0);
    bcd = 16'h0000;
    run_frame("f0000", {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, -1, 16'h0);

    bcd = 16'h1234;
    run_frame("ftear", AN_ALL, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4, 16'h5678);
    run_frame("f5678", AN_ALL, {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF, -1, 16'h0);

    bcd = 16'h00A5; dp_in = 4'b0010;
    run_frame("f00A5", {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {7'h7F, 7'h7F, 7'h3F, 7'h12}, 4'b1101, -1, 16'h0);
    chk("err_00A5", 16'(digit_err), 16'h1);
    bcd = 16'h0015; dp_in = 4'b0000;
    run_frame("f0015", {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {7'h7F, 7'h7F, 7'h79, 7'h12}, 4'hF, -1, 16'h0);
    chk("err_0015", 16'(digit_err), 16'h0);

    bcd = 16'h9A34;
    for (int f = 0; f < 10; f++) cyc();
    chk("pre_freeze_an", 16'(an), 16'hB);
    chk("pre_freeze_seg", 16'(seg), 16'h3F);
    chk("err_9A34", 16'(digit_err), 16'h1);
    enable = 1'b0;
    for (int f = 0; f < 3; f++) begin
      cyc();
      chk($sformatf("frz_an_%0d", f), 16'(an), 16'hF);
      chk($sformatf("frz_seg_%0d", f), 16'(seg), 16'h7F);
      chk($sformatf("frz_dp_%0d", f), 16'(dp), 16'h1);
      chk($sformatf("frz_fd_%0d", f), 16'(frame_done), 16'h0);
    end
    enable = 1'b1;
    cyc();
    chk("resume0_an", 16'(an), 16'hB);
    chk("resume0_seg", 16'(seg), 16'h3F);
    cyc();
    chk("resume1_an", 16'(an), 16'hB);
    chk("resume1_fd", 16'(frame_done), 16'h0);
    cyc();
    chk("resume2_an", 16'(an), 16'h7);
    chk("resume2_seg", 16'(seg), 16'h10);

    grst = 1'b0;
    cyc();
    chk_reset("midreset");
    grst = 1'b1; bcd = 16'h0007;
    run_frame("postrst", {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'hF, -1, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
